led_key_csr: RTL



---
 rtl/led_key_csr_pkg.sv | 20 ++
 rtl/led_key_csr_if.sv | 20 ++
 rtl/led_key_csr_key_debounce.sv | 37 +++
 rtl/led_key_csr.sv | 103 ++++++++++
 4 files changed

// File: rtl/led_key_csr_pkg.sv
// led_key_csr_pkg: register map offsets, CTRL fields and mode encoding shared by the LED/key CSR block.
package led_key_csr_pkg;

    localparam logic [2:0] ADDR_ID       = 3'd0;
    localparam logic [2:0] ADDR_CTRL     = 3'd1;
    localparam logic [2:0] ADDR_LED_VAL  = 3'd2;
    localparam logic [2:0] ADDR_INPUT    = 3'd3;
    localparam logic [2:0] ADDR_EDGE_CAP = 3'd4;
    localparam logic [2:0] ADDR_IRQ_MASK = 3'd5;

    localparam int CTRL_MODE_BIT = 0;

    localparam logic [31:0] ID_VALUE_DEF = 32'h1ED0_0001;

    typedef enum logic {
        MODE_COUNTER = 1'b0,
        MODE_MANUAL  = 1'b1
    } mode_e;

endpackage

// File: rtl/led_key_csr_if.sv
// led_key_csr_if: Avalon-MM slave bus (no waitrequest, fixed read latency 1).
interface led_key_csr_if;

    logic [2:0]  avs_address;
    logic        avs_read;
    logic [31:0] avs_readdata;
    logic        avs_write;
    logic [31:0] avs_writedata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );

endinterface

// File: rtl/led_key_csr_key_debounce.sv
// key_debounce: 2-flop synchroniser plus stability counter; fall pulses in the cycle an accepted 1->0 change lands.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter logic        RESET_VAL       = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout,
    output logic fall
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          state_q, state_d;
    logic          accept;

    assign accept  = (sync_q[1] != state_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
    assign cnt_d   = (sync_q[1] == state_q || accept) ? '0 : cnt_q + 1'b1;
    assign state_d = accept ? sync_q[1] : state_q;
    assign dout    = state_q;
    assign fall    = accept & ~sync_q[1];

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            sync_q  <= {2{RESET_VAL}};
            cnt_q   <= '0;
            state_q <= RESET_VAL;
        end else begin
            sync_q  <= {sync_q[0], din};
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end

endmodule

// File: rtl/led_key_csr.sv
// led_key_csr: Avalon-MM CSR driving LED[7:0] (blink counter or software value) and
// sampling debounced KEY[1:0] / synchronised SW[3:0], with W1C press capture and masked IRQ.
module led_key_csr
    import led_key_csr_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned CNT_W           = 28,
    parameter logic [31:0] ID_VALUE        = ID_VALUE_DEF
) (
    input  logic                clk,
    input  logic                reset_n,
    led_key_csr_if.slave        avs,
    input  logic [1:0]          key_n,
    input  logic [3:0]          sw,
    output logic [7:0]          led,
    output logic                irq
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    mode_e            mode_q, mode_d;
    logic [7:0]       led_val_q, led_val_d;
    logic [1:0]       edge_cap_q, edge_cap_d;
    logic [1:0]       irq_mask_q, irq_mask_d;
    logic [7:0]       led_q, led_d;
    logic             irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d, rd_mux;
    logic [3:0]       sw_s1_q, sw_s2_q;
    logic [1:0]       key_db, press;
    logic             wr_ctrl, wr_led, wr_ec, wr_mask;

    for (genvar k = 0; k < 2; k++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_VAL      (1'b1)
        ) u_db (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (key_n[k]),
            .dout   (key_db[k]),
            .fall   (press[k])
        );
    end

    assign wr_ctrl = avs.avs_write && avs.avs_address == ADDR_CTRL;
    assign wr_led  = avs.avs_write && avs.avs_address == ADDR_LED_VAL;
    assign wr_ec   = avs.avs_write && avs.avs_address == ADDR_EDGE_CAP;
    assign wr_mask = avs.avs_write && avs.avs_address == ADDR_IRQ_MASK;

    always_comb begin
        rd_mux = '0;
        case (avs.avs_address)
            ADDR_ID:       rd_mux = ID_VALUE;
            ADDR_CTRL:     rd_mux = {31'b0, mode_q == MODE_MANUAL};
            ADDR_LED_VAL:  rd_mux = {24'b0, led_val_q};
            ADDR_INPUT:    rd_mux = {24'b0, sw_s2_q, 2'b0, ~key_db};
            ADDR_EDGE_CAP: rd_mux = {30'b0, edge_cap_q};
            ADDR_IRQ_MASK: rd_mux = {30'b0, irq_mask_q};
            default:       rd_mux = '0;
        endcase
    end

    // A press landing in the same cycle as its W1C clear keeps the bit set.
    always_comb begin
        cnt_d      = cnt_q + 1'b1;
        mode_d     = wr_ctrl ? mode_e'(avs.avs_writedata[CTRL_MODE_BIT]) : mode_q;
        led_val_d  = wr_led ? avs.avs_writedata[7:0] : led_val_q;
        irq_mask_d = wr_mask ? avs.avs_writedata[1:0] : irq_mask_q;
        edge_cap_d = (edge_cap_q & ~(wr_ec ? avs.avs_writedata[1:0] : 2'b00)) | press;
        led_d      = mode_q == MODE_MANUAL ? led_val_q : cnt_d[CNT_W-1 -: 8];
        irq_d      = |(edge_cap_q & irq_mask_q);
        rdata_d    = avs.avs_read ? rd_mux : rdata_q;
    end

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            cnt_q      <= '0;
            mode_q     <= MODE_COUNTER;
            led_val_q  <= '0;
            edge_cap_q <= '0;
            irq_mask_q <= '0;
            led_q      <= '0;
            irq_q      <= 1'b0;
            rdata_q    <= '0;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
        end else begin
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            led_val_q  <= led_val_d;
            edge_cap_q <= edge_cap_d;
            irq_mask_q <= irq_mask_d;
            led_q      <= led_d;
            irq_q      <= irq_d;
            rdata_q    <= rdata_d;
            sw_s1_q    <= sw;
            sw_s2_q    <= sw_s1_q;
        end

    assign avs.avs_readdata = rdata_q;
    assign led              = led_q;
    assign irq              = irq_q;

endmodule
